trap_ctrl: RTL and testbench

Machine-mode trap/interrupt controller sitting between the commit stage and csr_file. Each cycle it checks the instruction at commit, together with the interrupt enable/pending state, mtvec and mepc supplied by csr_file. On a trap it stalls the pipeline, waits for outstanding memory activity to drain, writes mcause/mepc/mstatus through csr_file's control inputs, then flushes the pipeline and redirects fetch. It handles mret the same way in reverse.

---
 rtl/trap_ctrl_if.sv | 75 +++++++
 rtl/trap_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Commit-stage and csr_file signals seen by the trap controller.
// master drives commit/CSR state; slave is trap_ctrl itself.
interface trap_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  inst_valid_i;
  logic [DATA_WIDTH-1:0] inst_pc_i;
  logic                  inst_ecall_i;
  logic                  inst_ebreak_i;
  logic                  inst_illegal_i;
  logic                  inst_mret_i;
  logic                  mem_busy_i;
  logic                  mstatus_ie_i;
  logic                  mie_external_i;
  logic                  mie_timer_i;
  logic                  mie_software_i;
  logic                  mip_external_i;
  logic                  mip_timer_i;
  logic                  mip_software_i;
  logic [DATA_WIDTH-1:0] mtvec_i;
  logic [DATA_WIDTH-1:0] epc_i;

  logic                  stall_o;
  logic                  flush_o;
  logic                  redirect_o;
  logic [DATA_WIDTH-1:0] redirect_pc_o;
  logic                  commit_block_o;
  logic                  cause_we_o;
  logic [3:0]            cause_o;
  logic                  interrupt_type_o;
  logic                  epc_we_o;
  logic [DATA_WIDTH-1:0] epc_o;
  logic                  mstatus_ie_clear_o;
  logic                  mstatus_ie_set_o;

  modport master (
    output inst_valid_i, inst_pc_i,
    output inst_ecall_i, inst_ebreak_i,
    output inst_illegal_i, inst_mret_i,
    output mem_busy_i, mstatus_ie_i,
    output mie_external_i, mie_timer_i,
    output mie_software_i,
    output mip_external_i, mip_timer_i,
    output mip_software_i,
    output mtvec_i, epc_i,
    input  stall_o, flush_o,
    input  redirect_o, redirect_pc_o,
    input  commit_block_o,
    input  cause_we_o, cause_o,
    input  interrupt_type_o,
    input  epc_we_o, epc_o,
    input  mstatus_ie_clear_o,
    input  mstatus_ie_set_o
  );

  modport slave (
    input  inst_valid_i, inst_pc_i,
    input  inst_ecall_i, inst_ebreak_i,
    input  inst_illegal_i, inst_mret_i,
    input  mem_busy_i, mstatus_ie_i,
    input  mie_external_i, mie_timer_i,
    input  mie_software_i,
    input  mip_external_i, mip_timer_i,
    input  mip_software_i,
    input  mtvec_i, epc_i,
    output stall_o, flush_o,
    output redirect_o, redirect_pc_o,
    output commit_block_o,
    output cause_we_o, cause_o,
    output interrupt_type_o,
    output epc_we_o, epc_o,
    output mstatus_ie_clear_o,
    output mstatus_ie_set_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer between commit and csr_file.
// Detect in IDLE, drain memory, write CSRs, then flush and redirect.
module trap_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  trap_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SAVE,
    JUMP,
    MRET
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]            cause_q;
  logic [3:0]            cause_d;
  logic                  type_q;
  logic                  type_d;
  logic [DATA_WIDTH-1:0] epc_q;
  logic [DATA_WIDTH-1:0] epc_d;

  logic                  irq_ext;
  logic                  irq_tim;
  logic                  irq_sw;
  logic                  exc_req;
  logic                  irq_req;
  logic                  mret_req;
  logic [3:0]            exc_cause;
  logic [3:0]            irq_cause;
  logic [DATA_WIDTH-1:0] tvec_base;
  logic [DATA_WIDTH-1:0] tvec_off;
  logic [DATA_WIDTH-1:0] tvec_pc;

  assign irq_ext = bus.mie_external_i
                 & bus.mip_external_i;
  assign irq_tim = bus.mie_timer_i
                 & bus.mip_timer_i;
  assign irq_sw  = bus.mie_software_i
                 & bus.mip_software_i;

  assign exc_req = bus.inst_valid_i
                 & (bus.inst_illegal_i
                 |  bus.inst_ebreak_i
                 |  bus.inst_ecall_i);

  assign irq_req = bus.inst_valid_i
                 & bus.mstatus_ie_i
                 & (irq_ext | irq_tim | irq_sw);

  assign mret_req = bus.inst_valid_i
                  & bus.inst_mret_i;

  // Exception cause: illegal over ebreak over ecall.
  always_comb begin
    exc_cause = 4'd11;
    priority case (1'b1)
      bus.inst_illegal_i: exc_cause = 4'd2;
      bus.inst_ebreak_i:  exc_cause = 4'd3;
      default:            exc_cause = 4'd11;
    endcase
  end

  // Interrupt cause: external over software over timer.
  always_comb begin
    irq_cause = 4'd7;
    priority case (1'b1)
      irq_ext: irq_cause = 4'd11;
      irq_sw:  irq_cause = 4'd3;
      default: irq_cause = 4'd7;
    endcase
  end

  // Vectored mode only offsets interrupts; sum wraps naturally.
  assign tvec_base = {bus.mtvec_i[DATA_WIDTH-1:2], 2'b00};
  assign tvec_off  = DATA_WIDTH'({cause_q, 2'b00});
  assign tvec_pc   = (bus.mtvec_i[1:0] == 2'b01 && type_q)
                   ? tvec_base + tvec_off
                   : tvec_base;

  // State and latched trap context.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cause_q <= '0;
      type_q  <= 1'b0;
      epc_q   <= '0;
    end else begin
      state   <= state_nx;
      cause_q <= cause_d;
      type_q  <= type_d;
      epc_q   <= epc_d;
    end
  end

  // Next state, context capture and all outputs.
  // A busy memory port at detect time routes through WAIT;
  // otherwise the CSR write lands in the very next cycle.
  always_comb begin
    state_nx               = state;
    cause_d                = cause_q;
    type_d                 = type_q;
    epc_d                  = epc_q;
    bus.stall_o            = 1'b0;
    bus.flush_o            = 1'b0;
    bus.redirect_o         = 1'b0;
    bus.redirect_pc_o      = '0;
    bus.commit_block_o     = 1'b0;
    bus.cause_we_o         = 1'b0;
    bus.cause_o            = '0;
    bus.interrupt_type_o   = 1'b0;
    bus.epc_we_o           = 1'b0;
    bus.epc_o              = '0;
    bus.mstatus_ie_clear_o = 1'b0;
    bus.mstatus_ie_set_o   = 1'b0;

    unique case (state)
      IDLE: begin
        if (exc_req || irq_req) begin
          bus.stall_o        = 1'b1;
          bus.commit_block_o = 1'b1;
          cause_d  = exc_req ? exc_cause : irq_cause;
          type_d   = ~exc_req;
          epc_d    = bus.inst_pc_i;
          state_nx = bus.mem_busy_i ? WAIT : SAVE;
        end else if (mret_req) begin
          bus.stall_o = 1'b1;
          state_nx    = MRET;
        end
      end
      WAIT: begin
        bus.stall_o = 1'b1;
        if (!bus.mem_busy_i) begin
          state_nx = SAVE;
        end
      end
      SAVE: begin
        bus.stall_o            = 1'b1;
        bus.cause_we_o         = 1'b1;
        bus.epc_we_o           = 1'b1;
        bus.mstatus_ie_clear_o = 1'b1;
        bus.cause_o            = cause_q;
        bus.interrupt_type_o   = type_q;
        bus.epc_o              = epc_q;
        state_nx               = JUMP;
      end
      JUMP: begin
        bus.redirect_o    = 1'b1;
        bus.flush_o       = 1'b1;
        bus.redirect_pc_o = tvec_pc;
        state_nx          = IDLE;
      end
      MRET: begin
        bus.mstatus_ie_set_o = 1'b1;
        bus.redirect_o       = 1'b1;
        bus.flush_o          = 1'b1;
        bus.redirect_pc_o    = bus.epc_i;
        state_nx             = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Reset silences everything, including the detect path.
    if (rst_i) begin
      state_nx               = IDLE;
      bus.stall_o            = 1'b0;
      bus.flush_o            = 1'b0;
      bus.redirect_o         = 1'b0;
      bus.redirect_pc_o      = '0;
      bus.commit_block_o     = 1'b0;
      bus.cause_we_o         = 1'b0;
      bus.cause_o            = '0;
      bus.interrupt_type_o   = 1'b0;
      bus.epc_we_o           = 1'b0;
      bus.epc_o              = '0;
      bus.mstatus_ie_clear_o = 1'b0;
      bus.mstatus_ie_set_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR
// and redirect events, a negedge monitor pops and compares them.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  trap_ctrl_if #(.DATA_WIDTH(32)) bus ();

  trap_ctrl #(.DATA_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [76:0] ovec_t;

  typedef struct {
    int    at;
    string name;
    ovec_t v;
  } exp_t;

  exp_t q[$];

  function automatic ovec_t pack(
    input logic st, fl, rd,
    input logic [31:0] rpc,
    input logic blk, cwe,
    input logic [3:0] c,
    input logic ty, ewe,
    input logic [31:0] ep,
    input logic clr, set
  );
    return {st, fl, rd, rpc, blk, cwe, c, ty,
            ewe, ep, clr, set};
  endfunction

  function automatic ovec_t dut_vec();
    return pack(bus.stall_o, bus.flush_o,
                bus.redirect_o, bus.redirect_pc_o,
                bus.commit_block_o, bus.cause_we_o,
                bus.cause_o, bus.interrupt_type_o,
                bus.epc_we_o, bus.epc_o,
                bus.mstatus_ie_clear_o,
                bus.mstatus_ie_set_o);
  endfunction

  task automatic chk(input string n,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // Monitor: every cycle showing CSR or redirect activity must
  // match the oldest expected event, in the expected cycle.
  always @(negedge clk) begin
    exp_t  e;
    logic  act;
    act = bus.cause_we_o | bus.epc_we_o | bus.redirect_o
        | bus.flush_o | bus.mstatus_ie_clear_o
        | bus.mstatus_ie_set_o;
    if (q.size() > 0 && q[0].at < cyc) begin
      e = q.pop_front();
      chk({e.name, "_missed"}, 128'(cyc), 128'(e.at));
    end
    if (act) begin
      if (q.size() == 0) begin
        chk("unexpected_event", 128'(dut_vec()), 128'(0));
      end else begin
        e = q.pop_front();
        chk({e.name, "_cycle"}, 128'(cyc), 128'(e.at));
        chk(e.name, 128'(dut_vec()), 128'(e.v));
      end
    end
  end

  // Reference: classify the commit instruction from the rules.
  // kind 0 = nothing, 1 = trap, 2 = mret.
  function automatic void model(
    input logic v, ec, eb, il, mr, ie,
    input logic [2:0] en, pend,
    output int kind, output logic [3:0] c,
    output logic ty
  );
    logic [2:0] act;
    act  = en & pend;
    kind = 0;
    c    = 4'd0;
    ty   = 1'b0;
    if (v && (il || eb || ec)) begin
      kind = 1;
      c    = il ? 4'd2 : (eb ? 4'd3 : 4'd11);
    end else if (v && ie && act != 3'b000) begin
      kind = 1;
      ty   = 1'b1;
      if (act[2])      c = 4'd11;
      else if (act[0]) c = 4'd3;
      else             c = 4'd7;
    end else if (v && mr) begin
      kind = 2;
    end
  endfunction

  function automatic logic [31:0] trap_pc(
    input logic [31:0] tv, input logic [3:0] c,
    input logic ty
  );
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
    if (tv[1:0] == 2'b01 && ty)
      return base + 32'(c) * 32'd4;
    return base;
  endfunction

  task automatic idle_inputs();
    bus.inst_valid_i   = 1'b0;
    bus.inst_ecall_i   = 1'b0;
    bus.inst_ebreak_i  = 1'b0;
    bus.inst_illegal_i = 1'b0;
    bus.inst_mret_i    = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 128'(q.size()), 128'(0));
      q.delete();
    end
  endtask

  // en/pend bit order: {external, timer, software}.
  task automatic txn(
    input logic v, ec, eb, il, mr, ie,
    input logic [2:0] en, pend,
    input logic [31:0] pc, tv, ep,
    input int busy
  );
    int         t;
    int         kind;
    logic [3:0] c;
    logic       ty;
    exp_t       e;
    @(posedge clk);
    #1;
    bus.inst_valid_i   = v;
    bus.inst_ecall_i   = ec;
    bus.inst_ebreak_i  = eb;
    bus.inst_illegal_i = il;
    bus.inst_mret_i    = mr;
    bus.mstatus_ie_i   = ie;
    {bus.mie_external_i, bus.mie_timer_i,
     bus.mie_software_i} = en;
    {bus.mip_external_i, bus.mip_timer_i,
     bus.mip_software_i} = pend;
    bus.inst_pc_i  = pc;
    bus.mtvec_i    = tv;
    bus.epc_i      = ep;
    bus.mem_busy_i = (busy > 0);
    t = cyc;
    model(v, ec, eb, il, mr, ie, en, pend, kind, c, ty);
    #1;
    chk("detect_stall", 128'(bus.stall_o),
        128'(kind != 0));
    chk("detect_block", 128'(bus.commit_block_o),
        128'(kind == 1));
    if (kind == 1) begin
      e.at   = t + 1 + busy;
      e.name = "save";
      e.v    = pack(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1,
                    c, ty, 1'b1, pc, 1'b1, 1'b0);
      q.push_back(e);
      e.at   = t + 2 + busy;
      e.name = "jump";
      e.v    = pack(1'b0, 1'b1, 1'b1, trap_pc(tv, c, ty),
                    1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0,
                    1'b0, 1'b0);
      q.push_back(e);
    end else if (kind == 2) begin
      e.at   = t + 1;
      e.name = "mret";
      e.v    = pack(1'b0, 1'b1, 1'b1, ep, 1'b0, 1'b0,
                    4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      q.push_back(e);
    end
    for (int i = 1; i <= busy + 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) idle_inputs();
      bus.mem_busy_i = (i < busy);
      {bus.mip_external_i, bus.mip_timer_i,
       bus.mip_software_i} = 3'($urandom);
      #1;
      if (kind == 1 && i <= busy)
        chk("wait_stall", 128'(bus.stall_o), 128'(1));
    end
    drain();
  endtask

  initial begin
    int cnt;
    logic [31:0] r;
    idle_inputs();
    bus.inst_pc_i      = '0;
    bus.mem_busy_i     = 1'b0;
    bus.mstatus_ie_i   = 1'b0;
    bus.mie_external_i = 1'b0;
    bus.mie_timer_i    = 1'b0;
    bus.mie_software_i = 1'b0;
    bus.mip_external_i = 1'b0;
    bus.mip_timer_i    = 1'b0;
    bus.mip_software_i = 1'b0;
    bus.mtvec_i        = '0;
    bus.epc_i          = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 128'(dut_vec()), 128'(0));
    rst = 1'b0;
    #1;
    chk("idle_outputs", 128'(dut_vec()), 128'(0));

    // ecall, direct mtvec
    txn(1, 1, 0, 0, 0, 0, 3'b000, 3'b000,
        32'h80, 32'h100, 32'h0, 0);
    // timer interrupt, vectored mtvec
    txn(1, 0, 0, 0, 0, 1, 3'b010, 3'b010,
        32'h200, 32'h101, 32'h0, 0);
    // illegal beats all pending interrupts
    txn(1, 0, 0, 1, 0, 1, 3'b111, 3'b111,
        32'h300, 32'h101, 32'h0, 0);
    // return, then external wins
    txn(1, 0, 0, 0, 1, 0, 3'b111, 3'b111,
        32'h304, 32'h101, 32'h304, 0);
    txn(1, 0, 0, 0, 0, 1, 3'b111, 3'b111,
        32'h304, 32'h101, 32'h0, 0);
    // ebreak with memory busy for 3 cycles
    txn(1, 0, 1, 0, 0, 0, 3'b000, 3'b000,
        32'h400, 32'h200, 32'h0, 3);
    // mret
    txn(1, 0, 0, 0, 1, 0, 3'b000, 3'b000,
        32'h90, 32'h100, 32'h84, 0);
    // pending but globally disabled
    txn(1, 0, 0, 0, 0, 0, 3'b111, 3'b111,
        32'h500, 32'h100, 32'h0, 0);
    // interrupt beats mret
    txn(1, 0, 0, 0, 1, 1, 3'b001, 3'b001,
        32'h600, 32'hFFFF_FFFD, 32'h84, 0);

    // reset while waiting on memory
    @(posedge clk);
    #1;
    bus.inst_valid_i = 1'b1;
    bus.inst_ecall_i = 1'b1;
    bus.inst_pc_i    = 32'h700;
    bus.mem_busy_i   = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("wait_stall_pre_rst", 128'(bus.stall_o), 128'(1));
    rst = 1'b1;
    #1;
    chk("rst_in_wait", 128'(dut_vec()), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_idle", 128'(dut_vec()), 128'(0));
      @(posedge clk);
      #1;
    end

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      txn(r[0] | r[1], r[2] & r[3], r[4] & r[5],
          r[6] & r[7] & r[8], r[9], r[10],
          r[13:11], r[16:14],
          $urandom & 32'hFFFF_FFFC,
          $urandom, $urandom & 32'hFFFF_FFFC,
          int'(r[18:17]));
    end

    cnt = 0;
    while (q.size() > 0 && cnt < 20) begin
      @(posedge clk);
      cnt++;
    end
    if (q.size() > 0)
      chk("final_queue", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
